// File: rtl/npn_tt_sweep_ctrl.sv
// npn_tt_sweep_ctrl: drives every NIN-bit input vector through an external
// single-output network and assembles its response into a truth table.
// Optional compare against an expected table: define NPN_TT_SWEEP_CMP_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; tt holds the last result
// S_SWEEP | driving vectors 0..TTW-1 on x, one per cycle
// S_DRAIN | LAT cycles waiting for the network pipeline to empty
// S_DONE  | one-cycle done pulse; a new start may be accepted here
module npn_tt_sweep_ctrl #(
  parameter int NIN = 4,
  parameter int LAT = 0,
  localparam int TTW = 1 << NIN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [NIN-1:0] x,
  output logic           x_vld,
  input  logic           y,
  output logic           busy,
  output logic           done,
  output logic [TTW-1:0] tt
`ifdef NPN_TT_SWEEP_CMP_EN
  ,
  input  logic [TTW-1:0] exp_tt,
  output logic           match,
  output logic [NIN:0]   mism_cnt
`endif
);

  // A zero-latency network still gets a one-entry delay line so the array
  // is never empty; it is simply bypassed.
  localparam int DW = (LAT > 0) ? LAT : 1;
  localparam logic [2:0] DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t         state_q;
  logic [NIN:0]   cnt_q;
  logic [2:0]     drain_q;
  logic [NIN-1:0] x_q;
  logic           x_vld_q;
  logic           busy_q;
  logic           done_q;
  logic [TTW-1:0] tt_q;
  logic [TTW-1:0] tt_d;
  logic [NIN:0]   pipe_q [DW];

  logic           cap_vld;
  logic [NIN-1:0] cap_idx;
  logic           kill;
  logic           to_done;

  // Pick the (valid, index) pair whose network response is on y right now.
  always_comb begin
    cap_vld = 1'b0;
    cap_idx = '0;
    if (LAT == 0) begin
      cap_vld = x_vld_q;
      cap_idx = x_q;
    end else begin
      cap_vld = pipe_q[DW-1][NIN];
      cap_idx = pipe_q[DW-1][NIN-1:0];
    end
  end

  // Truth table with this cycle's capture applied; also feeds the compare.
  always_comb begin
    tt_d = tt_q;
    if (cap_vld) tt_d[cap_idx] = y;
  end

  // Abort only matters while busy; the done transition is shared with the compare.
  always_comb begin
    kill    = ((state_q == S_SWEEP) || (state_q == S_DRAIN)) && abort;
    to_done = !abort &&
              (((state_q == S_SWEEP) && cnt_q[NIN] && (LAT == 0)) ||
               ((state_q == S_DRAIN) && (drain_q == 3'd0)));
  end

  // Sweep sequencer, delay line and truth-table capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      x_q     <= '0;
      x_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      for (int i = 0; i < DW; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {x_vld_q, x_q};
      for (int i = 1; i < DW; i++) pipe_q[i] <= pipe_q[i-1];
      tt_q   <= tt_d;
      done_q <= 1'b0;
      if (kill) begin
        state_q <= S_IDLE;
        x_q     <= '0;
        x_vld_q <= 1'b0;
        busy_q  <= 1'b0;
        tt_q    <= '0;
        for (int i = 0; i < DW; i++) pipe_q[i] <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q <= S_SWEEP;
              cnt_q   <= (NIN+1)'(1);
              x_q     <= '0;
              x_vld_q <= 1'b1;
              busy_q  <= 1'b1;
              tt_q    <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_SWEEP: begin
            // cnt_q counts vectors already issued; its top bit marks the last one.
            if (cnt_q[NIN]) begin
              x_q     <= '0;
              x_vld_q <= 1'b0;
              if (LAT > 0) begin
                state_q <= S_DRAIN;
                drain_q <= DRAIN_LOAD;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              x_q   <= cnt_q[NIN-1:0];
              cnt_q <= cnt_q + (NIN+1)'(1);
            end
          end
          S_DRAIN: begin
            if (drain_q == 3'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q - 3'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign x     = x_q;
  assign x_vld = x_vld_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign tt    = tt_q;

`ifdef NPN_TT_SWEEP_CMP_EN
  logic [TTW-1:0] exp_q;
  logic           match_q;
  logic [NIN:0]   mism_q;
  logic [NIN:0]   mism_d;
  logic [TTW-1:0] diff;
  logic           accept;

  // Mismatch count of the final table against the expected one.
  always_comb begin
    diff   = tt_d ^ exp_q;
    mism_d = '0;
    for (int i = 0; i < TTW; i++) mism_d = mism_d + {{NIN{1'b0}}, diff[i]};
    accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  end

  // Expected table latched at start; result registered on entry to S_DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q   <= '0;
      match_q <= 1'b0;
      mism_q  <= '0;
    end else if (accept) begin
      exp_q   <= exp_tt;
      match_q <= 1'b0;
      mism_q  <= '0;
    end else if (kill) begin
      match_q <= 1'b0;
      mism_q  <= '0;
    end else if (to_done) begin
      match_q <= (mism_d == '0);
      mism_q  <= mism_d;
    end
  end

  assign match    = match_q;
  assign mism_cnt = mism_q;
`endif

endmodule

// File: tb/tb_npn_tt_sweep_ctrl.sv
// Bench for npn_tt_sweep_ctrl: one LAT=0 and one LAT=3 instance share a clock;
// one is exercised at a time. Compare outputs are checked when
// NPN_TT_SWEEP_CMP_EN is defined.
module tb_npn_tt_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [15:0] exp_tt, fn;
  int          sel;

  logic        start0, abort0, start3, abort3;
  logic [3:0]  x0, x3;
  logic        xv0, xv3, busy0, busy3, done0, done3, y0, y3;
  logic [15:0] tt0, tt3;
  logic [3:0]  xp [3];

  assign start0 = start && (sel == 0);
  assign abort0 = abort && (sel == 0);
  assign start3 = start && (sel != 0);
  assign abort3 = abort && (sel != 0);

  // Network: lookup of fn, combinational for dut0, 3-stage pipeline for dut3.
  assign y0 = fn[x0];
  assign y3 = fn[xp[2]];
  always_ff @(posedge clk) begin
    xp[0] <= x3;
    xp[1] <= xp[0];
    xp[2] <= xp[1];
  end

`ifdef NPN_TT_SWEEP_CMP_EN
  logic       m0, m3;
  logic [4:0] mc0, mc3;
`endif

  npn_tt_sweep_ctrl #(.NIN(4), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .x(x0), .x_vld(xv0), .y(y0), .busy(busy0), .done(done0), .tt(tt0)
`ifdef NPN_TT_SWEEP_CMP_EN
    , .exp_tt(exp_tt), .match(m0), .mism_cnt(mc0)
`endif
  );

  npn_tt_sweep_ctrl #(.NIN(4), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .x(x3), .x_vld(xv3), .y(y3), .busy(busy3), .done(done3), .tt(tt3)
`ifdef NPN_TT_SWEEP_CMP_EN
    , .exp_tt(exp_tt), .match(m3), .mism_cnt(mc3)
`endif
  );

  logic [3:0]  mx;
  logic        mxv, mbusy, mdone;
  logic [15:0] mtt;
  always_comb begin
    mx = x0; mxv = xv0; mbusy = busy0; mdone = done0; mtt = tt0;
    if (sel != 0) begin
      mx = x3; mxv = xv3; mbusy = busy3; mdone = done3; mtt = tt3;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: p = cycles since the accepting edge (0 = idle).
  int          p = 0;
  int          lat = 0;
  int          si = 0;
  int          k;
  int          cyc = 0;
  int          acc_edge = 0;
  int          n_done = 0, last_done = 0, prev_done = 0, n_drain = 0;
  logic [15:0] tt_m [2];
  logic [15:0] exp_m;
  logic        match_m [2];
  int          mc_m [2];
  bit          chk_en = 0;
  bit          eb, ev, ed;
  logic [3:0]  ex;

  initial begin
    tt_m[0] = '0; tt_m[1] = '0;
    match_m[0] = 0; match_m[1] = 0;
    mc_m[0] = 0; mc_m[1] = 0;
    exp_m = '0;
    forever begin
      @(posedge clk);
      cyc++;
      lat = (sel == 0) ? 0 : 3;
      si  = (sel == 0) ? 0 : 1;
      if (!rst_n) begin
        p = 0;
        for (int i = 0; i < 2; i++) begin
          tt_m[i] = '0; match_m[i] = 0; mc_m[i] = 0;
        end
      end else if (p >= 1 && p <= 16 + lat && abort) begin
        p = 0; tt_m[si] = '0; match_m[si] = 0; mc_m[si] = 0;
      end else if (!(p >= 1 && p <= 16 + lat) && start) begin
        p = 1; tt_m[si] = '0; exp_m = exp_tt; match_m[si] = 0; mc_m[si] = 0;
        acc_edge = cyc;
      end else if (p > 0) begin
        p++;
        k = p - lat - 2;
        if (k >= 0 && k < 16) tt_m[si][k] = fn[k];
        if (p == 17 + lat) begin
          mc_m[si] = $countones(fn ^ exp_m);
          match_m[si] = (mc_m[si] == 0);
        end
        if (p > 17 + lat) p = 0;
      end
      chk_en = 1;
    end
  end

  // Per-cycle comparison just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      eb = (p >= 1 && p <= 16 + lat);
      ev = (p >= 1 && p <= 16);
      ex = ev ? 4'(p - 1) : 4'd0;
      ed = (p == 17 + lat);
      chk("busy", 32'(mbusy), 32'(eb));
      chk("x_vld", 32'(mxv), 32'(ev));
      chk("x", 32'(mx), 32'(ex));
      chk("done", 32'(mdone), 32'(ed));
      chk("tt", 32'(mtt), 32'(tt_m[si]));
`ifdef NPN_TT_SWEEP_CMP_EN
      chk("match", 32'((sel == 0) ? m0 : m3), 32'(match_m[si]));
      chk("mism_cnt", 32'((sel == 0) ? mc0 : mc3), 32'(mc_m[si]));
`endif
      if (mdone) begin
        n_done++;
        prev_done = last_done;
        last_done = cyc;
      end
      if (mbusy && !mxv) n_drain++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int d0, dr0, ab_p;
  bit ab, aborted;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_tt = '0; fn = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_tt", 32'(mtt), 32'h0);
    chk("rst_busy", 32'(mbusy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // AND4, combinational
    fn = 16'h8000; exp_tt = 16'h8000; d0 = n_done;
    pulse_start();
    repeat (18) @(negedge clk);
    chk("and_tt", 32'(mtt), 32'h8000);
    chk("and_lat", 32'(last_done - acc_edge), 32'd16);
    chk("and_ndone", 32'(n_done - d0), 32'd1);
`ifdef NPN_TT_SWEEP_CMP_EN
    chk("and_match", 32'(m0), 32'd1);
    chk("and_mism", 32'(mc0), 32'd0);
    exp_tt = 16'h8001;
    pulse_start();
    repeat (18) @(negedge clk);
    chk("and_match_b", 32'(m0), 32'd0);
    chk("and_mism_b", 32'(mc0), 32'd1);
`endif

    // x0 ^ x1 through a 3-stage pipeline
    sel = 3; fn = 16'h6666; d0 = n_done; dr0 = n_drain;
    pulse_start();
    repeat (21) @(negedge clk);
    chk("xor_tt", 32'(mtt), 32'h6666);
    chk("xor_lat", 32'(last_done - acc_edge), 32'd19);
    chk("xor_drain", 32'(n_drain - dr0), 32'd3);
    chk("xor_ndone", 32'(n_done - d0), 32'd1);

    // Abort in cycle 8, then a clean sweep
    sel = 0; fn = 16'($urandom); exp_tt = fn; d0 = n_done;
    pulse_start();
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(mbusy), 32'd0);
    chk("abort_tt", 32'(mtt), 32'h0);
    repeat (20) @(negedge clk);
    chk("abort_ndone", 32'(n_done - d0), 32'd0);
    pulse_start();
    repeat (18) @(negedge clk);
    chk("post_abort_tt", 32'(mtt), 32'(fn));

    // Start held high: back-to-back sweeps
    d0 = n_done;
    start = 1'b1;
    repeat (60) @(negedge clk);
    chk("hold_ndone", 32'(n_done - d0), 32'd3);
    chk("hold_period", 32'(last_done - prev_done), 32'd17);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Reset during DRAIN
    sel = 3; fn = 16'($urandom); d0 = n_done;
    pulse_start();
    repeat (16) @(negedge clk);
    chk("in_drain", 32'(mbusy && !mxv), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_drain_busy", 32'(mbusy), 32'd0);
    chk("rst_drain_tt", 32'(mtt), 32'h0);
    chk("rst_drain_xv", 32'(mxv), 32'd0);
    repeat (25) @(negedge clk);
    chk("rst_drain_ndone", 32'(n_done - d0), 32'd0);

    // Random tables, random aborts, spurious starts while busy
    for (int it = 0; it < 40; it++) begin
      sel = ($urandom % 2 != 0) ? 3 : 0;
      fn = 16'($urandom);
      exp_tt = ($urandom % 2 != 0) ? fn : (fn ^ (16'd1 << ($urandom % 16)));
      ab = ($urandom % 4 == 0);
      ab_p = 1 + int'($urandom % ((sel == 0) ? 16 : 19));
      aborted = 0;
      d0 = n_done;
      pulse_start();
      for (int c = 0; c < 24; c++) begin
        abort = ab && (p == ab_p);
        if (abort) aborted = 1;
        start = (p >= 1 && p <= 14) ? ($urandom % 3 == 0) : 1'b0;
        @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      if (aborted) begin
        chk("rnd_abort_tt", 32'(mtt), 32'h0);
        chk("rnd_abort_ndone", 32'(n_done - d0), 32'd0);
      end else begin
        chk("rnd_tt", 32'(mtt), 32'(fn));
        chk("rnd_ndone", 32'(n_done - d0), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
